// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage types: M-extension op select, muldiv FSM states,
// and small decode helpers for operand signedness and op class.
package riscv_pkg;

  // Width of the muldiv op-select field
  localparam int MD_NUM = 3;

  typedef enum logic [MD_NUM-1:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } md_state_e;

  function automatic logic md_is_div(md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_is_rem(md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  // rs1 is treated as signed
  function automatic logic md_a_signed(md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // rs2 is treated as signed
  function automatic logic md_b_signed(md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/md_negate.sv
// Conditional two's-complement negation of a W-bit value.
// Latency: combinational, zero cycles.
// Backpressure: none, pure datapath.
module md_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] in_dat,
  output logic [W-1:0] out_dat
);

  assign out_dat = en ? (~in_dat + W'(1)) : in_dat;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency: XLEN+1 cycles iterative; 1 cycle for div-by-zero, signed overflow and fast multiplies.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. Build option: MULDIV_FAST_MUL_EN.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  md_op_e          op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int W2 = 2 * XLEN;

  md_state_e       state_q, state_d;
  md_op_e          op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;        // |rs1|: multiplicand
  logic [XLEN-1:0] b_q, b_d;        // |rs2|: divisor
  logic            a_neg_q, a_neg_d;
  logic            b_neg_q, b_neg_d;
  logic            is_div_q, is_div_d;
  logic [W2-1:0]   acc_q, acc_d;    // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            out_valid_q, out_valid_d;

  // Incoming operand magnitudes and sign flags
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_sgn = md_a_signed(op) & operand_a[XLEN-1];
  assign b_sgn = md_b_signed(op) & operand_b[XLEN-1];

  md_negate #(.W(XLEN)) u_neg_a (.en(a_sgn), .in_dat(operand_a), .out_dat(a_mag));
  md_negate #(.W(XLEN)) u_neg_b (.en(b_sgn), .in_dat(operand_b), .out_dat(b_mag));

  // Divide special cases resolved without iterating
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  assign div_zero = (operand_b == '0);
  assign div_ovf  = md_b_signed(op) && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);

  // Quotient/remainder values for divide-by-zero and most-negative / -1
  always_comb begin
    if (div_zero) special_res = md_is_rem(op) ? operand_a : '1;
    else          special_res = md_is_rem(op) ? '0 : operand_a;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extended operands: the low 2*XLEN bits of this product equal those of
  // the (XLEN+1)x(XLEN+1) signed product, which is all any mul op needs.
  logic [W2-1:0]   fast_a, fast_b, fast_prod;
  logic [XLEN-1:0] fast_res;

  assign fast_a    = {{XLEN{md_a_signed(op) & operand_a[XLEN-1]}}, operand_a};
  assign fast_b    = {{XLEN{md_b_signed(op) & operand_b[XLEN-1]}}, operand_b};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (op == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[W2-1:XLEN];
`endif

  // One shift-add multiply step: add multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  logic [XLEN:0]   mul_sum;
  logic [W2-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring-divide step: shift in the next dividend bit and subtract the
  // divisor when it fits; the borrow decides the quotient bit.
  logic [XLEN:0]   div_rem_sh, div_diff;
  logic [W2-1:0]   div_next, acc_step;

  assign div_rem_sh = acc_q[W2-1:XLEN-1];
  assign div_diff   = div_rem_sh - {1'b0, b_q};
  assign div_next   = div_diff[XLEN] ? {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
  assign acc_step   = is_div_q ? div_next : mul_next;

  // Result sign fix-up on the final step's value
  logic            fix_en;
  logic [W2-1:0]   fix_in, fix_out;
  logic [XLEN-1:0] iter_res;

  // Pick what to negate: full product, quotient, or remainder (sign of dividend)
  always_comb begin
    fix_in = acc_step;
    fix_en = a_neg_q ^ b_neg_q;
    if (is_div_q) begin
      if (md_is_rem(op_q)) begin
        fix_in = {{XLEN{1'b0}}, acc_step[W2-1:XLEN]};
        fix_en = a_neg_q;
      end else begin
        fix_in = {{XLEN{1'b0}}, acc_step[XLEN-1:0]};
      end
    end
  end

  md_negate #(.W(W2)) u_neg_res (.en(fix_en), .in_dat(fix_in), .out_dat(fix_out));

  assign iter_res = (is_div_q || op_q == MD_MUL) ? fix_out[XLEN-1:0] : fix_out[W2-1:XLEN];

  // Next-state and datapath update; kill overrides everything
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    a_neg_d     = a_neg_q;
    b_neg_d     = b_neg_q;
    is_div_d    = is_div_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && !kill) begin
          op_d     = op;
          a_d      = a_mag;
          b_d      = b_mag;
          a_neg_d  = a_sgn;
          b_neg_d  = b_sgn;
          is_div_d = md_is_div(op);
          cnt_d    = '0;
          acc_d    = md_is_div(op) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          if (md_is_div(op)) begin
            if (div_zero || div_ovf) begin
              result_d    = special_res;
              out_valid_d = 1'b1;
              state_d     = ST_DONE;
            end else begin
              state_d = ST_DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            result_d    = fast_res;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
`else
            state_d = ST_MUL;
`endif
          end
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          result_d    = iter_res;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
        else           out_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (kill) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= MD_MUL;
      a_q         <= '0;
      b_q         <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      is_div_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      is_div_q    <= is_div_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
